// File: rtl/sdram_slave_model_if.sv
// Avalon-MM memory port between a layer master and the SDRAM responder model.
// It carries the command, write-data and read-response signals.
interface sdram_slave_model_if;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] address;
    logic [1:0]  byteenable;
    logic [15:0] writedata;
    logic        waitrequest;
    logic        readdatavalid;
    logic [15:0] readdata;

    modport master (
        output chipselect, read_n, write_n, address, byteenable, writedata,
        input  waitrequest, readdatavalid, readdata
    );

    modport slave (
        input  chipselect, read_n, write_n, address, byteenable, writedata,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/sdram_slave_model.sv
// Avalon-MM responder standing in for the SDRAM controller: byte-enabled writes, fixed-latency
// in-order pipelined reads, an outstanding-read throttle and an optional periodic stall.
module sdram_slave_model #(
    parameter int unsigned DEPTH        = 262144,
    parameter int unsigned ADDR_BITS    = 18,
    parameter int unsigned READ_LATENCY = 3,
    parameter int unsigned MAX_PENDING  = 4,
    parameter int unsigned STALL_PERIOD = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    sdram_slave_model_if.slave  bus,
    output logic                err,
    output logic [31:0]         rd_accepted
);

    localparam int unsigned PendBits  = $clog2(MAX_PENDING + 1);
    localparam int unsigned StallBits = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    typedef enum logic {StInit, StRun} state_e;

    state_e                         state_q, state_d;
    logic [15:0]                    mem [DEPTH];
    logic [PendBits-1:0]            pending_q, pending_d;
    logic [READ_LATENCY-1:0]        pipe_vld_q, pipe_vld_d;
    logic [READ_LATENCY-1:0][15:0]  pipe_data_q, pipe_data_d;
    logic [StallBits-1:0]           stall_cnt_q, stall_cnt_d;
    logic                           err_q, err_d;
    logic [31:0]                    rd_acc_q, rd_acc_d;

    logic                 in_range;
    logic [ADDR_BITS-1:0] mem_idx;
    logic                 cmd_rd, cmd_wr, cmd_both;
    logic                 wait_req, stall_tick;
    logic                 rd_acc, wr_acc, rd_ret;
    logic [15:0]          rd_word;

    // Full 32-bit compare so set upper bits count as out of range.
    assign in_range = (bus.address < DEPTH);
    assign mem_idx  = bus.address[ADDR_BITS-1:0];

    assign cmd_rd   = bus.chipselect & ~bus.read_n &  bus.write_n;
    assign cmd_wr   = bus.chipselect &  bus.read_n & ~bus.write_n;
    assign cmd_both = bus.chipselect & ~bus.read_n & ~bus.write_n;

    assign stall_tick = (STALL_PERIOD != 0) &&
                        (stall_cnt_q == StallBits'(STALL_PERIOD - 1));

    // Built from registered state only, so a master may look at it before driving read_n/write_n.
    assign wait_req = (state_q == StInit) | stall_tick |
                      (pending_q == PendBits'(MAX_PENDING));

    assign rd_acc  = cmd_rd & ~wait_req;
    assign wr_acc  = cmd_wr & ~wait_req;
    assign rd_ret  = pipe_vld_q[READ_LATENCY-1];
    assign rd_word = in_range ? mem[mem_idx] : 16'h0000;

    assign bus.waitrequest   = wait_req;
    assign bus.readdatavalid = rd_ret;
    assign bus.readdata      = pipe_data_q[READ_LATENCY-1];
    assign err               = err_q;
    assign rd_accepted       = rd_acc_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        pipe_vld_d     = '0;
        pipe_data_d    = '0;
        pipe_vld_d[0]  = rd_acc;
        pipe_data_d[0] = rd_acc ? rd_word : 16'h0000;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end
    end

    always_comb begin
        pending_d = pending_q;
        case ({rd_acc, rd_ret})
            2'b10:   pending_d = pending_q + PendBits'(1);
            2'b01:   pending_d = pending_q - PendBits'(1);
            default: pending_d = pending_q;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q + StallBits'(1);
        if (STALL_PERIOD <= 1 || stall_tick) begin
            stall_cnt_d = '0;
        end
    end

    always_comb begin
        err_d    = err_q | cmd_both | ((rd_acc | wr_acc) & ~in_range);
        rd_acc_d = rd_acc ? rd_acc_q + 32'd1 : rd_acc_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StInit;
            pending_q   <= '0;
            pipe_vld_q  <= '0;
            pipe_data_q <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
            rd_acc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_data_q <= pipe_data_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
            rd_acc_q    <= rd_acc_d;
        end
    end

    // Storage is deliberately not reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            if (bus.byteenable[0]) mem[mem_idx][7:0]  <= bus.writedata[7:0];
            if (bus.byteenable[1]) mem[mem_idx][15:8] <= bus.writedata[15:8];
        end
    end

endmodule

// File: tb/tb_sdram_slave_model.sv
// Bench for sdram_slave_model: directed traffic, with a transaction-level model
// (memory map + queue of due responses) checked against the DUT on every cycle.
module tb_sdram_slave_model;

    localparam int unsigned Depth  = 262144;
    localparam int unsigned Lat    = 3;
    localparam int unsigned MaxP   = 2;
    localparam int unsigned StallP = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sdram_slave_model_if bus ();
    logic        err;
    logic [31:0] rd_accepted;

    sdram_slave_model #(
        .DEPTH       (Depth),
        .ADDR_BITS   (18),
        .READ_LATENCY(Lat),
        .MAX_PENDING (MaxP),
        .STALL_PERIOD(StallP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .err        (err),
        .rd_accepted(rd_accepted)
    );

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    endtask

    typedef struct {
        int unsigned due;
        logic [15:0] data;
    } resp_t;

    resp_t       q[$];
    logic [15:0] mem_m [int unsigned];
    int unsigned cyc = 0;
    logic        err_m = 1'b0;
    logic [31:0] acc_m = '0;
    int unsigned rdv_seen = 0;
    logic [15:0] last_rd = '0;
    int          out_cnt = 0;
    int          max_out = 0;
    logic        exp_wait, exp_rdv;

    function automatic logic [15:0] mem_get(input int unsigned a);
        return mem_m.exists(a) ? mem_m[a] : 16'h0000;
    endfunction

    // Model: cycle c after reset release is throttled when c==0, c%StallP==StallP-1,
    // or MaxP responses are still owed; a read accepted in cycle c returns in cycle c+Lat.
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
            cyc = 0;
            err_m = 1'b0;
            acc_m = '0;
            out_cnt = 0;
            check("rst_waitrequest", bus.waitrequest, 1);
            check("rst_readdatavalid", bus.readdatavalid, 0);
            check("rst_readdata", bus.readdata, 0);
            check("rst_err", err, 0);
            check("rst_rd_accepted", rd_accepted, 0);
        end else begin
            exp_wait = (cyc == 0) || (cyc % StallP == StallP - 1) || (q.size() == MaxP);
            exp_rdv  = (q.size() != 0) && (q[0].due == cyc);
            check("waitrequest", bus.waitrequest, exp_wait);
            check("readdatavalid", bus.readdatavalid, exp_rdv);
            if (exp_rdv) check("readdata", bus.readdata, q[0].data);
            check("err", err, err_m);
            check("rd_accepted", rd_accepted, acc_m);

            if (bus.readdatavalid) begin
                rdv_seen++;
                last_rd = bus.readdata;
                out_cnt--;
            end
            if (bus.chipselect && !bus.read_n && bus.write_n && !bus.waitrequest) out_cnt++;
            if (out_cnt > max_out) max_out = out_cnt;

            if (exp_rdv) void'(q.pop_front());
            if (bus.chipselect) begin
                if (!bus.read_n && !bus.write_n) begin
                    err_m = 1'b1;
                end else if (!exp_wait && !bus.read_n) begin
                    acc_m++;
                    if (bus.address < Depth) q.push_back('{cyc + Lat, mem_get(bus.address)});
                    else begin
                        q.push_back('{cyc + Lat, 16'h0000});
                        err_m = 1'b1;
                    end
                end else if (!exp_wait && !bus.write_n) begin
                    if (bus.address < Depth) begin
                        logic [15:0] w;
                        w = mem_get(bus.address);
                        if (bus.byteenable[0]) w[7:0]  = bus.writedata[7:0];
                        if (bus.byteenable[1]) w[15:8] = bus.writedata[15:8];
                        mem_m[bus.address] = w;
                    end else begin
                        err_m = 1'b1;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic idle();
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
    endtask

    // Hold the driven command until a cycle without waitrequest, then step past its edge.
    task automatic wait_accept(input string name);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!bus.waitrequest) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        n_total++;
        $display("FAIL %s: got no accept, expected accept within 64 cycles", name);
        @(posedge clk);
        #1;
    endtask

    task automatic cmd_read(input logic [31:0] a);
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = a;
        wait_accept("read_accept");
    endtask

    task automatic cmd_write(input logic [31:0] a, input logic [15:0] d, input logic [1:0] be);
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        bus.byteenable = be;
        wait_accept("write_accept");
    endtask

    task automatic wait_rdv(input int unsigned target, input string name);
        for (int i = 0; i < 100; i++) begin
            if (rdv_seen >= target) return;
            @(posedge clk);
            #1;
        end
        n_total++;
        $display("FAIL %s: got %0d responses, expected %0d", name, rdv_seen, target);
    endtask

    int unsigned base;

    initial begin
        idle();
        bus.address    = '0;
        bus.byteenable = '0;
        bus.writedata  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("init_waitrequest", bus.waitrequest, 1);

        // Image fill and back-to-back readback.
        for (int i = 0; i < 784; i++) cmd_write(i, 16'(i & 1), 2'b11);
        idle();
        base = rdv_seen;
        for (int i = 0; i < 784; i++) cmd_read(i);
        idle();
        wait_rdv(base + 784, "t1_drain");
        check("t1_rdv_count", rdv_seen - base, 784);
        check("t1_rd_accepted", rd_accepted, 784);
        check("t1_err", err, 0);

        // Reads held back-to-back against the outstanding limit.
        max_out = 0;
        base = rdv_seen;
        for (int i = 100; i < 110; i++) cmd_read(i);
        idle();
        wait_rdv(base + 10, "t2_drain");
        check("t2_rdv_count", rdv_seen - base, 10);
        check("t2_max_outstanding", max_out, 2);
        check("t2_rd_accepted", rd_accepted, 794);

        // Byte-enable merge, and byteenable=00 leaves the word alone.
        cmd_write(900, 16'h1234, 2'b11);
        cmd_write(900, 16'hABCD, 2'b10);
        base = rdv_seen;
        cmd_read(900);
        idle();
        wait_rdv(base + 1, "t3_read");
        check("t3_merge", last_rd, 16'hAB34);
        cmd_write(900, 16'hFFFF, 2'b00);
        base = rdv_seen;
        cmd_read(900);
        idle();
        wait_rdv(base + 1, "t3_be00");
        check("t3_be00", last_rd, 16'hAB34);

        // Continuous reads through periodic stalls.
        base = rdv_seen;
        for (int i = 0; i < 12; i++) cmd_read(i);
        idle();
        wait_rdv(base + 12, "t4_drain");
        check("t4_rdv_count", rdv_seen - base, 12);
        check("t4_rd_accepted", rd_accepted, 808);

        // Out-of-range accesses.
        cmd_write(32'h0003_FFFF, 16'h5A5A, 2'b11);
        idle();
        @(posedge clk);
        #1;
        check("t5_err_before", err, 0);
        base = rdv_seen;
        cmd_read(Depth + 5);
        idle();
        wait_rdv(base + 1, "t5_oor_read");
        check("t5_oor_data", last_rd, 16'h0000);
        check("t5_err_after", err, 1);
        cmd_write(32'hFFFF_FFFF, 16'hDEAD, 2'b11);
        base = rdv_seen;
        cmd_read(32'h0003_FFFF);
        idle();
        wait_rdv(base + 1, "t5_alias_read");
        check("t5_alias_unchanged", last_rd, 16'h5A5A);
        check("t5_rd_accepted", rd_accepted, 810);

        // Reset with reads in flight.
        cmd_read(10);
        cmd_read(11);
        reset_n = 1'b0;
        idle();
        #1;
        check("t6_waitrequest", bus.waitrequest, 1);
        check("t6_readdatavalid", bus.readdatavalid, 0);
        check("t6_readdata", bus.readdata, 0);
        check("t6_err", err, 0);
        check("t6_rd_accepted", rd_accepted, 0);
        base = rdv_seen;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("t6_init_wait", bus.waitrequest, 1);
        repeat (8) @(posedge clk);
        #1;
        check("t6_no_stale_rdv", rdv_seen - base, 0);

        // Read and write strobes together: no access, sticky error.
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        bus.write_n    = 1'b0;
        bus.address    = 32'd5;
        wait_accept("t7_both_low");
        idle();
        base = rdv_seen;
        repeat (5) @(posedge clk);
        #1;
        check("t7_err", err, 1);
        check("t7_rd_accepted", rd_accepted, 0);
        check("t7_no_rdv", rdv_seen - base, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
